// File: rtl/audio_ctrl_pkg.sv
// Shared types and helpers for the audio record/playback sequencer.
// State encoding matches the externally visible state port.
package audio_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RECORD     = 3'd1,
    ST_PLAY       = 3'd2,
    ST_PAUSE_REC  = 3'd3,
    ST_PAUSE_PLAY = 3'd4
  } state_t;

  localparam int SAMPLE_W  = 16;
  localparam int SPEED_MAX = 8;

  // A factor of 0 means 1; anything above SPEED_MAX saturates.
  function automatic logic [3:0] clamp_factor(input logic [3:0] f);
    if (f == 4'd0) return 4'd1;
    if (f > 4'(SPEED_MAX)) return 4'(SPEED_MAX);
    return f;
  endfunction

endpackage

// File: rtl/sram_port_seq.sv
// One-shot SRAM strobe sequencer: a write holds we_n low for one cycle, a read
// holds oe_n low for one cycle and captures the read data as it releases.
module sram_port_seq
  import audio_ctrl_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_go,
  input  logic                wr_go,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] rdata,
  output logic                rdata_valid,
  output logic                rd_busy,
  output logic                wr_busy,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [SAMPLE_W-1:0] sram_wdata,
  input  logic [SAMPLE_W-1:0] sram_rdata,
  output logic                sram_we_n,
  output logic                sram_oe_n
);

  assign rd_busy = ~sram_oe_n;
  assign wr_busy = ~sram_we_n;

  // Stage boundary: launch (address/strobe) -> release (capture/complete).
  // A strobe is only launched when both are high, so they never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_wdata  <= '0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      if (!sram_oe_n) begin
        sram_oe_n <= 1'b1;
        if (!abort) begin
          rdata       <= sram_rdata;
          rdata_valid <= 1'b1;
        end
      end else if (!sram_we_n) begin
        sram_we_n <= 1'b1;
      end else if (wr_go) begin
        sram_addr  <= addr;
        sram_wdata <= wdata;
        sram_we_n  <= 1'b0;
      end else if (rd_go) begin
        sram_addr <= addr;
        sram_oe_n <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/audio_ctrl.sv
// Record/playback sequencer owning the shared codec SRAM.
// Optional build macro LOOP_PLAY_EN: playback wraps to address 0 instead of stopping.
module audio_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 18,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 18'h3FFFF
) (
  input  logic                bclk,
  input  logic                rst,
  input  logic                key_record,
  input  logic                key_play,
  input  logic                key_pause,
  input  logic                key_stop,
  input  logic                speed_mode,
  input  logic [3:0]          speed_factor,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                dac_req,
  output logic [SAMPLE_W-1:0] dac_data,
  output logic                dac_valid,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [SAMPLE_W-1:0] sram_wdata,
  input  logic [SAMPLE_W-1:0] sram_rdata,
  output logic                sram_we_n,
  output logic                sram_oe_n,
  output logic [2:0]          state,
  output logic [ADDR_W-1:0]   rec_end,
  output logic                done
);

  state_t            cur_st, nxt_st;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, port_addr;
  logic [3:0]        rep_cnt, rep_nxt, spd_fac_p0;
  logic              spd_mode_p0, has_rec;
  logic              rd_go, wr_go, rd_busy, wr_busy, port_idle;
  logic              start_play, clear_wr, rd_commit, wrap_play, done_nxt;
  logic [ADDR_W:0]   rd_nxt;
  logic              past_end;

  assign state     = cur_st;
  assign port_idle = ~rd_busy & ~wr_busy;
  assign port_addr = wr_go ? wr_ptr : rd_ptr;

  sram_port_seq #(.ADDR_W(ADDR_W)) u_port (
    .clk         (bclk),
    .rst         (rst),
    .rd_go       (rd_go),
    .wr_go       (wr_go),
    .abort       (key_stop),
    .addr        (port_addr),
    .wdata       (adc_data),
    .rdata       (dac_data),
    .rdata_valid (dac_valid),
    .rd_busy     (rd_busy),
    .wr_busy     (wr_busy),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  // Read-pointer advance, computed one bit wider so running past the end never wraps.
  always_comb begin
    rd_nxt  = {1'b0, rd_ptr};
    rep_nxt = 4'd0;
    if (!spd_mode_p0)
      rd_nxt = {1'b0, rd_ptr} + {{(ADDR_W-3){1'b0}}, spd_fac_p0};
    else if (rep_cnt >= spd_fac_p0 - 4'd1)
      rd_nxt = {1'b0, rd_ptr} + 1'b1;
    else
      rep_nxt = rep_cnt + 4'd1;
    past_end = rd_nxt > {1'b0, rec_end};
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) cur_st <= ST_IDLE;
    else     cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st     = cur_st;
    rd_go      = 1'b0;
    wr_go      = 1'b0;
    start_play = 1'b0;
    clear_wr   = 1'b0;
    rd_commit  = 1'b0;
    wrap_play  = 1'b0;
    done_nxt   = 1'b0;
    case (cur_st)
      ST_IDLE: begin
        if (!key_stop && !key_pause) begin
          if (key_play && has_rec) begin
            nxt_st     = ST_PLAY;
            start_play = 1'b1;
          end else if (key_record) begin
            nxt_st   = ST_RECORD;
            clear_wr = 1'b1;
          end
        end
      end
      ST_RECORD: begin
        if (wr_busy && wr_ptr == MAX_ADDR) begin
          done_nxt = 1'b1;
          nxt_st   = ST_IDLE;
        end else if (key_stop) begin
          nxt_st = ST_IDLE;
        end else if (key_pause) begin
          nxt_st = ST_PAUSE_REC;
        end else if (adc_valid && port_idle) begin
          wr_go = 1'b1;
        end
      end
      ST_PLAY: begin
        if (key_stop) begin
          nxt_st = ST_IDLE;
        end else if (rd_busy) begin
          rd_commit = 1'b1;
          if (past_end) begin
            done_nxt = 1'b1;
`ifdef LOOP_PLAY_EN
            wrap_play = 1'b1;
            if (key_pause) nxt_st = ST_PAUSE_PLAY;
`else
            nxt_st = ST_IDLE;
`endif
          end else if (key_pause) begin
            nxt_st = ST_PAUSE_PLAY;
          end
        end else if (key_pause) begin
          nxt_st = ST_PAUSE_PLAY;
        end else if (dac_req && port_idle) begin
          rd_go = 1'b1;
        end
      end
      ST_PAUSE_REC: begin
        if (key_stop)       nxt_st = ST_IDLE;
        else if (key_pause) nxt_st = ST_RECORD;
      end
      ST_PAUSE_PLAY: begin
        if (key_stop)       nxt_st = ST_IDLE;
        else if (key_pause) nxt_st = ST_PLAY;
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  // Speed settings are latched with each accepted request (_p0) and used when it completes.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rep_cnt     <= 4'd0;
      rec_end     <= '0;
      has_rec     <= 1'b0;
      spd_mode_p0 <= 1'b0;
      spd_fac_p0  <= 4'd1;
      done        <= 1'b0;
    end else begin
      done <= done_nxt;
      if (clear_wr) begin
        wr_ptr <= '0;
      end else if (wr_busy) begin
        rec_end <= wr_ptr;
        wr_ptr  <= wr_ptr + 1'b1;
        has_rec <= 1'b1;
      end
      if (start_play || wrap_play) begin
        rd_ptr  <= '0;
        rep_cnt <= 4'd0;
      end else if (rd_commit) begin
        rd_ptr  <= rd_nxt[ADDR_W-1:0];
        rep_cnt <= rep_nxt;
      end
      if (rd_go) begin
        spd_mode_p0 <= speed_mode;
        spd_fac_p0  <= clamp_factor(speed_factor);
      end
    end
  end

endmodule

// File: tb/tb_audio_ctrl.sv
// Directed + randomized bench for audio_ctrl with a behavioural SRAM and playback model.
module tb_audio_ctrl;

  logic        bclk = 1'b0;
  logic        rst;
  logic        key_record, key_play, key_pause, key_stop;
  logic        speed_mode;
  logic [3:0]  speed_factor;
  logic        adc_valid;
  logic [15:0] adc_data;
  logic        dac_req;
  logic [15:0] dac_data;
  logic        dac_valid;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n, sram_oe_n;
  logic [2:0]  state;
  logic [17:0] rec_end;
  logic        done;

  audio_ctrl #(.ADDR_W(18), .MAX_ADDR(18'd7)) dut (
    .bclk(bclk), .rst(rst),
    .key_record(key_record), .key_play(key_play), .key_pause(key_pause), .key_stop(key_stop),
    .speed_mode(speed_mode), .speed_factor(speed_factor),
    .adc_valid(adc_valid), .adc_data(adc_data), .dac_req(dac_req),
    .dac_data(dac_data), .dac_valid(dac_valid),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .state(state), .rec_end(rec_end), .done(done)
  );

  always #5 bclk = ~bclk;

  logic [15:0] mem [0:255];
  always @(posedge bclk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_wdata;
  assign sram_rdata = !sram_oe_n ? mem[sram_addr[7:0]] : 16'hDEAD;

  typedef struct packed { logic [17:0] addr; logic [15:0] data; } wr_t;
  wr_t         wr_log[$];
  logic [15:0] rec_q[$];
  int n_cmp = 0, n_bad = 0, both_low = 0;

  always @(negedge bclk) begin
    if (!sram_we_n) wr_log.push_back({sram_addr, sram_wdata});
    if (!sram_we_n && !sram_oe_n) both_low++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run exceeded time limit (observed running, expected finished)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // k = {stop, pause, play, record}
  task automatic pulse(input logic [3:0] k);
    @(negedge bclk);
    {key_stop, key_pause, key_play, key_record} = k;
    @(negedge bclk);
    {key_stop, key_pause, key_play, key_record} = 4'b0000;
  endtask

  task automatic adc_push(input logic [15:0] v, output logic dn, output logic [2:0] st);
    @(negedge bclk); adc_valid = 1'b1; adc_data = v;
    @(negedge bclk); adc_valid = 1'b0;
    @(negedge bclk); dn = done; st = state;
    @(negedge bclk);
  endtask

  task automatic do_req(output logic got, output logic [15:0] d, output logic dn);
    @(negedge bclk); dac_req = 1'b1;
    @(negedge bclk); dac_req = 1'b0;
    chk("valid_at_1cycle", 32'(dac_valid), 32'd0);
    @(negedge bclk); got = dac_valid; d = dac_data; dn = done;
    repeat (14) @(negedge bclk);
  endtask

  task automatic check_writes(input int base, input int n);
    chk("write_count", 32'(wr_log.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < wr_log.size(); i++) begin
      chk("write_addr", 32'(wr_log[base+i].addr), 32'(i));
      chk("write_data", 32'(wr_log[base+i].data), 32'(rec_q[i]));
    end
  endtask

  // Expected k-th output: fast skips by factor, slow repeats each sample factor times.
  task automatic play_check(input logic mode, input logic [3:0] fac);
    int eff, total, n;
    logic got, dn;
    logic [15:0] d, exp;
    n     = rec_q.size();
    eff   = (fac == 0) ? 1 : ((fac > 8) ? 8 : int'(fac));
    total = mode ? n * eff : (n + eff - 1) / eff;
    speed_mode = mode; speed_factor = fac;
    pulse(4'b0010);
    chk("play_start_state", 32'(state), 32'd2);
    for (int k = 0; k < total; k++) begin
      exp = mode ? rec_q[k / eff] : rec_q[k * eff];
      do_req(got, d, dn);
      chk("play_valid", 32'(got), 32'd1);
      chk("play_data", 32'(d), 32'(exp));
      chk("play_done", 32'(dn), (k == total - 1) ? 32'd1 : 32'd0);
    end
`ifdef LOOP_PLAY_EN
    chk("loop_state", 32'(state), 32'd2);
    do_req(got, d, dn);
    chk("loop_valid", 32'(got), 32'd1);
    chk("loop_data", 32'(d), 32'(rec_q[0]));
    chk("loop_done", 32'(dn), (total == 1) ? 32'd1 : 32'd0);
`else
    chk("end_state", 32'(state), 32'd0);
`endif
    pulse(4'b1000);
    chk("after_stop_state", 32'(state), 32'd0);
  endtask

  initial begin
    logic dn, got;
    logic [2:0] st;
    logic [15:0] d, v;
    int base;
    rst = 1'b1;
    {key_stop, key_pause, key_play, key_record} = 4'b0000;
    speed_mode = 1'b0; speed_factor = 4'd1;
    adc_valid = 1'b0; adc_data = 16'h0; dac_req = 1'b0;
    repeat (3) @(negedge bclk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_dac_valid", 32'(dac_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rec_end", 32'(rec_end), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_wdata", 32'(sram_wdata), 32'd0);
    chk("rst_dac_data", 32'(dac_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge bclk);

    pulse(4'b0010);
    chk("play_without_rec", 32'(state), 32'd0);

    // Fixed four-sample recording.
    pulse(4'b0001);
    chk("rec_state", 32'(state), 32'd1);
    base = wr_log.size();
    rec_q.delete();
    for (int i = 0; i < 4; i++) begin
      v = 16'(16'h1111 * (i + 1));
      rec_q.push_back(v);
      adc_push(v, dn, st);
      chk("rec_done", 32'(dn), 32'd0);
      chk("rec_state_hold", 32'(st), 32'd1);
    end
    pulse(4'b1000);
    chk("rec_stop_state", 32'(state), 32'd0);
    check_writes(base, 4);
    chk("rec_end_4", 32'(rec_end), 32'd3);

    play_check(1'b0, 4'd2);
    play_check(1'b1, 4'd3);

    // Pause in the middle of playback; requests while paused are dropped.
    speed_mode = 1'b0; speed_factor = 4'd1;
    pulse(4'b0010);
    for (int k = 0; k < 2; k++) begin
      do_req(got, d, dn);
      chk("pre_pause_data", 32'(d), 32'(rec_q[k]));
    end
    pulse(4'b0100);
    chk("pause_state", 32'(state), 32'd4);
    for (int k = 0; k < 5; k++) begin
      do_req(got, d, dn);
      chk("paused_valid", 32'(got), 32'd0);
      chk("paused_oe_n", 32'(sram_oe_n), 32'd1);
    end
    pulse(4'b0100);
    chk("resume_state", 32'(state), 32'd2);
    for (int k = 2; k < 4; k++) begin
      do_req(got, d, dn);
      chk("resume_valid", 32'(got), 32'd1);
      chk("resume_data", 32'(d), 32'(rec_q[k]));
      chk("resume_done", 32'(dn), (k == 3) ? 32'd1 : 32'd0);
    end
    pulse(4'b1000);

    // Paused recording ignores adc_valid.
    pulse(4'b0001);
    base = wr_log.size();
    rec_q.delete();
    for (int i = 0; i < 2; i++) begin
      v = 16'($urandom_range(0, 65535));
      rec_q.push_back(v);
      adc_push(v, dn, st);
    end
    pulse(4'b0100);
    chk("pause_rec_state", 32'(state), 32'd3);
    for (int i = 0; i < 2; i++) begin
      adc_push(16'($urandom_range(0, 65535)), dn, st);
      chk("pause_rec_hold", 32'(st), 32'd3);
    end
    pulse(4'b0100);
    chk("unpause_rec_state", 32'(state), 32'd1);
    v = 16'($urandom_range(0, 65535));
    rec_q.push_back(v);
    adc_push(v, dn, st);
    pulse(4'b1000);
    check_writes(base, 3);
    chk("rec_end_3", 32'(rec_end), 32'd2);
    play_check(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // Stop and play together while recording: stop wins.
    pulse(4'b0001);
    chk("rec_again_state", 32'(state), 32'd1);
    pulse(4'b1010);
    chk("stop_play_state", 32'(state), 32'd0);
    chk("rec_end_kept", 32'(rec_end), 32'd2);

    // Reset in the middle of a read.
    pulse(4'b0010);
    @(negedge bclk); dac_req = 1'b1;
    @(negedge bclk); dac_req = 1'b0;
    chk("read_in_flight", 32'(sram_oe_n), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_addr", 32'(sram_addr), 32'd0);
    chk("midrst_rec_end", 32'(rec_end), 32'd0);
    chk("midrst_dac_data", 32'(dac_data), 32'd0);
    @(negedge bclk);
    chk("midrst_dac_valid", 32'(dac_valid), 32'd0);
    rst = 1'b0;
    @(negedge bclk);
    pulse(4'b0010);
    chk("play_after_rst", 32'(state), 32'd0);

    // Fill memory up to MAX_ADDR.
    pulse(4'b0001);
    base = wr_log.size();
    rec_q.delete();
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom_range(0, 65535));
      rec_q.push_back(v);
      adc_push(v, dn, st);
      chk("full_done", 32'(dn), (i == 7) ? 32'd1 : 32'd0);
      chk("full_state", 32'(st), (i == 7) ? 32'd0 : 32'd1);
    end
    check_writes(base, 8);
    chk("full_rec_end", 32'(rec_end), 32'd7);
    for (int i = 0; i < 2; i++) adc_push(16'($urandom_range(0, 65535)), dn, st);
    chk("no_write_after_full", 32'(wr_log.size() - base), 32'd8);

    for (int r = 0; r < 4; r++)
      play_check(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    chk("strobes_never_overlap", 32'(both_low), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_ctrl.md
Name: audio_ctrl

Overview:
- Top-level record/playback sequencer for the codec path; owns the single-port SRAM shared between the ADC capture side and the DAC serializer.
- Decodes key pulses into an IDLE/RECORD/PLAY/PAUSE state machine.
- Generates SRAM read/write strobes and addresses, and applies fast/slow playback speed.
- The DAC serializer only issues per-frame sample requests; this block supplies addresses and samples.

Parameters:
ADDR_W, 18, SRAM word-address width
MAX_ADDR, 18'h3FFFF, last writable SRAM word

Ports:
bclk  in  1  codec bit clock; all logic on posedge
rst  in  1  asynchronous active-high reset
key_record  in  1  one-cycle pulse: start recording
key_play  in  1  one-cycle pulse: start playback
key_pause  in  1  one-cycle pulse: toggle pause
key_stop  in  1  one-cycle pulse: abort to IDLE
speed_mode  in  1  0 = fast, 1 = slow
speed_factor  in  4  1..8; 0 treated as 1, >8 clamped to 8
adc_valid  in  1  one-cycle pulse: adc_data holds a new sample
adc_data  in  16  captured sample
dac_req  in  1  one-cycle pulse: serializer needs the next sample
dac_data  out  16  sample to serializer
dac_valid  out  1  one-cycle pulse: dac_data valid
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  16  SRAM write data
sram_rdata  in  16  SRAM read data
sram_we_n  out  1  write strobe, active low
sram_oe_n  out  1  output enable, active low
state  out  3  current FSM state encoding
rec_end  out  ADDR_W  last recorded address
done  out  1  one-cycle pulse: playback finished or record memory full

Behaviour:
- Reset values:
  - state = IDLE; sram_addr = 0; sram_wdata = 0; dac_data = 0.
  - sram_we_n = 1; sram_oe_n = 1; dac_valid = 0; done = 0; rec_end = 0.
  - Internal wr_ptr, rd_ptr and rep_cnt = 0.
- States: IDLE=0, RECORD=1, PLAY=2, PAUSE_REC=3, PAUSE_PLAY=4.
- Key priority when several pulse in one cycle: stop > pause > play > record.
- IDLE:
  - key_record -> RECORD; wr_ptr = 0.
  - key_play -> PLAY; rd_ptr = 0, rep_cnt = 0. Ignored if rec_end == 0 and nothing has been recorded; an internal has_rec flag tracks this.
- RECORD:
  - adc_valid: sram_addr = wr_ptr, sram_wdata = adc_data, sram_we_n low for exactly one cycle (next cycle).
  - After the write: rec_end = wr_ptr, wr_ptr++.
  - Write at MAX_ADDR -> done pulse, go to IDLE.
  - dac_req ignored.
- PLAY, on dac_req:
  - Cycle 1: sram_addr = rd_ptr, sram_oe_n = 0.
  - Cycle 2: dac_data = sram_rdata, dac_valid = 1, sram_oe_n = 1. Latency is 2 cycles from dac_req to dac_valid.
  - Fast mode: rd_ptr += factor.
  - Slow mode: rep_cnt++. When rep_cnt == factor-1: rep_cnt = 0 and rd_ptr++. Each sample is therefore output factor times.
  - If the new rd_ptr > rec_end, compared in ADDR_W+1 bits so no wrap: done pulse, go to IDLE.
- dac_req arriving while a read is in flight is dropped. The serializer guarantees ≥16 cycles between requests.
- key_pause:
  - RECORD <-> PAUSE_REC; PLAY <-> PAUSE_PLAY.
  - Pointers are held while paused.
  - In PAUSE states, adc_valid and dac_req are ignored and no strobes are issued.
- key_stop in any state:
  - Goes to IDLE next cycle; strobes return high.
  - An in-flight write completes its single we_n cycle first. An in-flight read is abandoned with no dac_valid.
  - rec_end is kept.
- Speed inputs are sampled at each dac_req, so a change takes effect on the next sample.
- rst mid-operation clears everything, including rec_end.
- sram_we_n and sram_oe_n are never low simultaneously.

Optional Feature:
- Macro LOOP_PLAY_EN.
  - Defined: when the new rd_ptr > rec_end in PLAY, set rd_ptr = 0 and rep_cnt = 0, pulse done, and stay in PLAY. Playback loops until key_stop or key_pause.
  - Undefined: go to IDLE as described above.

Decomposition:
- Package audio_ctrl_pkg:
  - State enum localparams (IDLE..PAUSE_PLAY).
  - SAMPLE_W = 16 and SPEED_MAX = 8.
  - Factor-clamp function.
- Sub-module sram_port_seq:
  - One-shot read/write strobe sequencer.
  - Inputs: rd_go/wr_go, addr, wdata.
  - Outputs: rdata_valid and the SRAM pins.
- FSM and pointer logic live in audio_ctrl.

Test Plan:
- Record 4 samples 0x1111..0x4444 via adc_valid, then key_stop -> four single-cycle we_n pulses at addresses 0..3; rec_end = 3; state = IDLE.
- Play with speed_mode = 0, factor = 2 -> dac_data sequence 0x1111, 0x3333, then done pulse and state IDLE. With LOOP_PLAY_EN, the next request returns 0x1111 again.
- Play with speed_mode = 1, factor = 3 -> each sample output 3 times, 12 dac_valid in total; dac_valid exactly 2 cycles after each dac_req.
- key_pause during PLAY after 2 samples, 5 dac_req pulses while paused, key_pause again -> no dac_valid while paused; resumes at the 3rd output with the same rd_ptr.
- key_stop and key_play in the same cycle during RECORD -> IDLE. rst asserted mid-read -> all outputs return to reset values immediately, with no dac_valid.
- Record with MAX_ADDR set to 7 -> 8 writes, done pulse, IDLE; further adc_valid pulses produce no we_n.
